carrier_modulator: RTL and testbench

- Transmit-side BPSK carrier modulator. It is the counterpart of the receiver's local-carrier NCO.
- Accepts one data bit per symbol over a valid/ready handshake. For each bit it generates SAMPLES_PER_SYM carrier samples from a phase accumulator and a cosine LUT.
- Bit 0 transmits +cos and bit 1 transmits -cos.
- Output sample stream feeds the channel/DAC model and the receiver testbench loopback. One sample per clock while active.

---
 rtl/carrier_modulator_pkg.sv | 36 +++
 rtl/carrier_modulator_if.sv | 30 +++
 rtl/carrier_cos_lut.sv | 34 +++
 rtl/carrier_modulator.sv | 113 +++++++++++
 tb/tb_carrier_modulator.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/carrier_modulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carrier_modulator_pkg
// Description : Shared constants, state encoding and cosine table generator
//               for the BPSK carrier modulator and the receiver NCO.
// Revision    : 1.0 - initial release
// ============================================================================
package carrier_modulator_pkg;

    localparam int C_SAMPLE_W = 32;
    localparam int C_PHASE_W  = 32;

    // Default 2^32 * fc/fs for fc/fs = 1/4; the receiver NCO uses the same value.
    localparam logic [C_PHASE_W-1:0] C_PHASE_INC_DEF = 32'h4000_0000;
    localparam int                   C_LUT_BITS_DEF  = 8;

    localparam logic [0:0] C_ST_IDLE   = 1'b0;
    localparam logic [0:0] C_ST_ACTIVE = 1'b1;

    // Q2.30 cosine entry, rounded half away from zero; only evaluated at elaboration.
    function automatic logic signed [C_SAMPLE_W-1:0] cos_q30(input int idx, input int bits);
        real v_ang;
        real v_val;
        int  v_mag;
        v_ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(1 << bits);
        v_val = $cos(v_ang) * 1073741824.0;
        if (v_val >= 0.0) begin
            v_mag = $rtoi(v_val + 0.5);
            return v_mag;
        end
        v_mag = $rtoi(0.5 - v_val);
        return -v_mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/carrier_modulator_if.sv
`default_nettype none
// ============================================================================
// Module      : carrier_modulator_if
// Description : Bit-in handshake and sample-out stream of the carrier modulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface carrier_modulator_if;
    import carrier_modulator_pkg::*;

    logic                         bit_valid;
    logic                         bit_data;
    logic                         bit_ready;
    logic signed [C_SAMPLE_W-1:0] phase_offset;
    logic                         sample_valid;
    logic signed [C_SAMPLE_W-1:0] sample_out;
    logic        [C_PHASE_W-1:0]  phase_acc;
    logic                         busy;

    modport master (
        output bit_valid, bit_data, phase_offset,
        input  bit_ready, sample_valid, sample_out, phase_acc, busy
    );

    modport slave (
        input  bit_valid, bit_data, phase_offset,
        output bit_ready, sample_valid, sample_out, phase_acc, busy
    );

endinterface
`default_nettype wire

// File: rtl/carrier_cos_lut.sv
`default_nettype none
// ============================================================================
// Module      : carrier_cos_lut
// Description : Registered-output cosine ROM, 2^LUT_BITS x Q2.30 entries.
// Revision    : 1.0 - initial release
// ============================================================================
module carrier_cos_lut
    import carrier_modulator_pkg::*;
#(
    parameter int LUT_BITS = C_LUT_BITS_DEF
) (
    input  logic                         clk,
    input  logic [LUT_BITS-1:0]          i_addr,
    output logic signed [C_SAMPLE_W-1:0] o_data
);

    localparam int C_DEPTH = 1 << LUT_BITS;

    logic signed [C_SAMPLE_W-1:0] w_rom [C_DEPTH];
    logic signed [C_SAMPLE_W-1:0] r_data;

    for (genvar gi = 0; gi < C_DEPTH; gi++) begin : g_rom
        localparam logic signed [C_SAMPLE_W-1:0] C_ENTRY = cos_q30(gi, LUT_BITS);
        assign w_rom[gi] = C_ENTRY;
    end

    always_ff @(posedge clk) begin
        r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/carrier_modulator.sv
`default_nettype none
// ============================================================================
// Module      : carrier_modulator
// Description : BPSK carrier modulator; SAMPLES_PER_SYM +/-cos samples per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module carrier_modulator
    import carrier_modulator_pkg::*;
#(
    parameter logic [C_PHASE_W-1:0] PHASE_INC       = C_PHASE_INC_DEF,
    parameter int                   SAMPLES_PER_SYM = 8,
    parameter int                   LUT_BITS        = C_LUT_BITS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    carrier_modulator_if.slave mod_if
);

    localparam int                 C_CNT_W = $clog2(SAMPLES_PER_SYM);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(SAMPLES_PER_SYM - 1);

    logic [0:0]                   r_state;
    logic [C_CNT_W-1:0]           r_sym_cnt;
    logic                         r_symbol;
    logic [C_PHASE_W-1:0]         r_phase_acc;
    logic                         r_s1_valid;
    logic                         r_s1_symbol;
    logic                         r_s2_valid;
    logic signed [C_SAMPLE_W-1:0] r_sample;

    logic                         w_issue;
    logic                         w_at_last;
    logic                         w_bit_ready;
    logic                         w_xfer;
    logic [C_PHASE_W-1:0]         w_phase;
    logic [LUT_BITS-1:0]          w_lut_addr;
    logic signed [C_SAMPLE_W-1:0] w_cos;

    assign w_issue     = (r_state == C_ST_ACTIVE);
    assign w_at_last   = (r_sym_cnt == C_LAST);
    // Gated by reset so the upstream never sees ready while the block is held.
    assign w_bit_ready = reset && ((r_state == C_ST_IDLE) || (w_issue && w_at_last));
    assign w_xfer      = w_bit_ready && mod_if.bit_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= C_ST_IDLE;
            r_sym_cnt   <= '0;
            r_symbol    <= 1'b0;
            r_phase_acc <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_xfer) begin
                        r_symbol  <= mod_if.bit_data;
                        r_sym_cnt <= '0;
                        r_state   <= C_ST_ACTIVE;
                    end
                end
                C_ST_ACTIVE: begin
                    r_phase_acc <= r_phase_acc + PHASE_INC;
                    if (!w_at_last) begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end else if (w_xfer) begin
                        r_symbol  <= mod_if.bit_data;
                        r_sym_cnt <= '0;
                    end else begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    // Stage 1: the ROM's own output register holds the cosine of phase_acc + offset.
    assign w_phase    = r_phase_acc + $unsigned(mod_if.phase_offset);
    assign w_lut_addr = LUT_BITS'(w_phase >> (C_PHASE_W - LUT_BITS));

    carrier_cos_lut #(
        .LUT_BITS (LUT_BITS)
    ) u_cos_lut (
        .clk    (clk),
        .i_addr (w_lut_addr),
        .o_data (w_cos)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_symbol <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_sample    <= '0;
        end else begin
            r_s1_valid  <= w_issue;
            r_s1_symbol <= r_symbol;
            r_s2_valid  <= r_s1_valid;
            if (r_s1_valid) begin
                r_sample <= r_s1_symbol ? -w_cos : w_cos;
            end else begin
                r_sample <= '0;
            end
        end
    end

    assign mod_if.bit_ready    = w_bit_ready;
    assign mod_if.sample_valid = r_s2_valid;
    assign mod_if.sample_out   = r_sample;
    assign mod_if.phase_acc    = r_phase_acc;
    assign mod_if.busy         = w_issue || r_s1_valid || r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_carrier_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_carrier_modulator
// Description : Directed self-checking bench for carrier_modulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carrier_modulator;
    import carrier_modulator_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    carrier_modulator_if ifa();
    carrier_modulator_if ifb();

    carrier_modulator u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .mod_if (ifa.slave)
    );

    carrier_modulator #(
        .PHASE_INC       (32'h2000_0000),
        .SAMPLES_PER_SYM (2),
        .LUT_BITS        (8)
    ) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .mod_if (ifb.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] e_pos0 [8] = '{32'h4000_0000, 32'h0, 32'hC000_0000, 32'h0,
                                32'h4000_0000, 32'h0, 32'hC000_0000, 32'h0};
    logic [31:0] e_neg0 [8] = '{32'hC000_0000, 32'h0, 32'h4000_0000, 32'h0,
                                32'hC000_0000, 32'h0, 32'h4000_0000, 32'h0};
    logic [31:0] e_q90  [8] = '{32'h0, 32'hC000_0000, 32'h0, 32'h4000_0000,
                                32'h0, 32'hC000_0000, 32'h0, 32'h4000_0000};
    // cos(2*pi*k/8) in Q2.30, hand-rounded
    int cos8 [8] = '{1073741824, 759250125, 0, -759250125,
                     -1073741824, -759250125, 0, 759250125};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready_a();
        for (int i = 0; i < 40 && ifa.bit_ready !== 1'b1; i++) @(negedge clk);
        check("wait_ready", ifa.bit_ready, 32'd1);
    endtask

    // Returns at the falling edge just after the transfer edge.
    task automatic send_a(input logic b);
        wait_ready_a();
        ifa.bit_valid = 1'b1;
        ifa.bit_data  = b;
        @(negedge clk);
        ifa.bit_valid = 1'b0;
    endtask

    task automatic expect_stream(input string tag, input logic [31:0] exp [8]);
        check({tag, "_lat0"}, ifa.sample_valid, 32'd0);
        check({tag, "_busy"}, ifa.busy, 32'd1);
        @(negedge clk);
        check({tag, "_lat1"}, ifa.sample_valid, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, "_valid"}, ifa.sample_valid, 32'd1);
            check({tag, "_sample"}, ifa.sample_out, exp[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] m_phase;
        logic [31:0] q [$];
        logic [31:0] v_exp;
        int          sent;
        int          got;
        int          c;

        ifa.bit_valid = 1'b0; ifa.bit_data = 1'b0; ifa.phase_offset = '0;
        ifb.bit_valid = 1'b0; ifb.bit_data = 1'b0; ifb.phase_offset = '0;

        // Reset state
        @(negedge clk);
        check("rst_valid", ifa.sample_valid, 32'd0);
        check("rst_sample", ifa.sample_out, 32'd0);
        check("rst_ready", ifa.bit_ready, 32'd0);
        check("rst_busy", ifa.busy, 32'd0);
        check("rst_phase", ifa.phase_acc, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", ifa.bit_ready, 32'd1);

        // Single bit 0
        send_a(1'b0);
        expect_stream("t1", e_pos0);
        @(negedge clk);
        check("t1_end_valid", ifa.sample_valid, 32'd0);
        check("t1_end_sample", ifa.sample_out, 32'd0);
        check("t1_end_busy", ifa.busy, 32'd0);
        check("t1_end_phase", ifa.phase_acc, 32'd0);

        // Back-to-back bits 1,0 with bit_valid held high
        wait_ready_a();
        ifa.bit_valid = 1'b1;
        ifa.bit_data  = 1'b1;
        @(negedge clk);
        ifa.bit_data  = 1'b0;
        for (int j = 1; j <= 19; j++) begin
            if (j > 1) @(negedge clk);
            if (j <= 15) check("t2_ready", ifa.bit_ready, (j == 8) ? 32'd1 : 32'd0);
            if (j >= 3 && j <= 18) begin
                check("t2_valid", ifa.sample_valid, 32'd1);
                check("t2_sample", ifa.sample_out, (j < 11) ? e_neg0[j-3] : e_pos0[j-11]);
            end else begin
                check("t2_gap_valid", ifa.sample_valid, 32'd0);
            end
            if (j == 8) begin
                @(negedge clk);
                ifa.bit_valid = 1'b0;
                j++;
                check("t2_ready", ifa.bit_ready, 32'd0);
                check("t2_valid", ifa.sample_valid, 32'd1);
                check("t2_sample", ifa.sample_out, e_neg0[j-3]);
            end
        end

        // 90 degree offset, then negative offset with an inverted bit
        ifa.phase_offset = 32'sh4000_0000;
        send_a(1'b0);
        expect_stream("t3", e_q90);
        ifa.phase_offset = -32'sh4000_0000;
        send_a(1'b1);
        expect_stream("t3n", e_q90);
        ifa.phase_offset = '0;

        // Idle gap keeps phase
        send_a(1'b0);
        expect_stream("t4a", e_pos0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_gap_phase", ifa.phase_acc, 32'd0);
            check("t4_gap_valid", ifa.sample_valid, 32'd0);
        end
        send_a(1'b0);
        check("t4_start_phase", ifa.phase_acc, 32'd0);
        expect_stream("t4b", e_pos0);

        // Reset at sample 3 of a symbol
        @(negedge clk);
        send_a(1'b0);
        repeat (5) @(negedge clk);
        check("t5_pre_valid", ifa.sample_valid, 32'd1);
        check("t5_pre_phase", ifa.phase_acc, 32'h4000_0000);
        reset = 1'b0;
        #1;
        check("t5_valid", ifa.sample_valid, 32'd0);
        check("t5_sample", ifa.sample_out, 32'd0);
        check("t5_ready", ifa.bit_ready, 32'd0);
        check("t5_busy", ifa.busy, 32'd0);
        check("t5_phase", ifa.phase_acc, 32'd0);
        @(negedge clk);
        check("t5_hold_valid", ifa.sample_valid, 32'd0);
        reset = 1'b1;
        send_a(1'b1);
        expect_stream("t5b", e_neg0);

        // Short symbols, random bits and gaps against a reference model
        m_phase = '0;
        sent    = 0;
        got     = 0;
        c       = 0;
        while (c < 600 && !(sent == 24 && q.size() == 0 && ifb.busy === 1'b0)) begin
            @(negedge clk);
            c++;
            if (ifb.sample_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("t6_unexpected", ifb.sample_valid, 32'd0);
                end else begin
                    v_exp = q.pop_front();
                    check("t6_sample", ifb.sample_out, v_exp);
                    got++;
                end
            end
            ifb.bit_valid = (sent < 24) && ($urandom_range(0, 2) != 0);
            ifb.bit_data  = 1'($urandom_range(0, 1));
            if (ifb.bit_valid && ifb.bit_ready === 1'b1) begin
                sent++;
                for (int s = 0; s < 2; s++) begin
                    v_exp = cos8[m_phase[31:29]];
                    q.push_back(ifb.bit_data ? -v_exp : v_exp);
                    m_phase = m_phase + 32'h2000_0000;
                end
            end
        end
        ifb.bit_valid = 1'b0;
        check("t6_bits_sent", sent, 32'd24);
        check("t6_sample_count", got, 32'd48);
        check("t6_drained", q.size(), 32'd0);
        check("t6_phase", ifb.phase_acc, m_phase);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
